// File: rtl/clock_alarm_pkg.sv
// rtl/clock_alarm_pkg.sv - shared types, segment codes and BCD helpers for the clock/alarm controller
package clock_alarm_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10
  } mode_t;

  // Active-low seven-segment codes, bit7 is the decimal point (kept off)
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  // Field limits as packed BCD {tens, units}
  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
  localparam logic [7:0] BCD_SEC_MAX  = 8'h59;

  // Add one to a packed BCD field, wrapping to 00 after the limit
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] value, input logic [7:0] limit);
    logic [7:0] result;
    if (value == limit) begin
      result = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD digit to active-low seven-segment code
module bcd_to_7seg
  import clock_alarm_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Digits 0-9 map to their glyph; anything else is shown blank
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_alarm_ctrl.sv
// rtl/clock_alarm_ctrl.sv - time-keeping, set-mode and alarm controller driving six digits and status leds
module clock_alarm_ctrl
  import clock_alarm_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ALARM_SECS      = 60
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       set_mode_button,
  input  logic       inc_hour_button,
  input  logic       inc_min_button,
  input  logic       inc_sec_button,
  output logic [7:0] hour_1,
  output logic [7:0] hour_2,
  output logic [7:0] min_1,
  output logic [7:0] min_2,
  output logic [7:0] sec_1,
  output logic [7:0] sec_2,
  output logic [7:0] leds
);

  localparam int TB_W = $clog2(CLK_HZ);
  localparam int DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int AL_W = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;

  localparam logic [TB_W-1:0] TB_LAST    = TB_W'(CLK_HZ - 1);
  localparam logic [DB_W-1:0] LOCK_LOAD  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [AL_W-1:0] RING_TICKS = AL_W'(ALARM_SECS);

  // Button index: 3 = set_mode, 2 = hour, 1 = min, 0 = sec (also the priority order)
  logic [3:0] btn_raw;
  logic [3:0] btn_sync1;
  logic [3:0] btn_sync2;
  logic [3:0] btn_sync2_d;
  logic [3:0] btn_edge;
  logic [3:0] accept;
  logic [DB_W-1:0] lockout [4];

  mode_t mode;
  mode_t mode_next;

  logic [TB_W-1:0] tb_cnt;
  logic            tick;

  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       armed;

  logic            ringing;
  logic            blink;
  logic [AL_W-1:0] ring_left;

  logic any_press;
  logic silence;
  logic do_set;
  logic do_hour;
  logic do_min;
  logic do_sec;
  logic enter_set_time;

  logic [7:0] hour_inc;
  logic [7:0] min_inc;
  logic [7:0] sec_inc;
  logic [7:0] alarm_hour_inc;
  logic [7:0] alarm_min_inc;
  logic [7:0] next_hour;
  logic [7:0] next_min;
  logic       ring_start;

  logic [7:0] disp_hour;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] seg_hour_1;
  logic [7:0] seg_hour_2;
  logic [7:0] seg_min_1;
  logic [7:0] seg_min_2;
  logic [7:0] seg_sec_1;
  logic [7:0] seg_sec_2;
  logic [1:0] mode_bits;

  assign btn_raw = {set_mode_button, inc_hour_button, inc_min_button, inc_sec_button};

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      btn_sync1   <= '0;
      btn_sync2   <= '0;
      btn_sync2_d <= '0;
    end else begin
      btn_sync1   <= btn_raw;
      btn_sync2   <= btn_sync1;
      btn_sync2_d <= btn_sync2;
    end
  end

  assign btn_edge = btn_sync2 & ~btn_sync2_d;

  // An edge counts only when that button's lockout has expired
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = btn_edge[i] && (lockout[i] == '0);
    end
  end

  // Per-button lockout: every accepted edge reloads, even one that loses priority
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset_reset) begin
        lockout[i] <= '0;
      end else if (accept[i]) begin
        lockout[i] <= LOCK_LOAD;
      end else if (lockout[i] != '0) begin
        lockout[i] <= lockout[i] - DB_W'(1);
      end
    end
  end

  // Resolve accepted presses: while ringing any press only silences
  always_comb begin
    any_press      = |accept;
    silence        = ringing && any_press;
    do_set         = !ringing && accept[3];
    do_hour        = !ringing && !accept[3] && accept[2];
    do_min         = !ringing && !accept[3] && !accept[2] && accept[1];
    do_sec         = !ringing && !accept[3] && !accept[2] && !accept[1] && accept[0];
    enter_set_time = do_set && (mode == RUN);
  end

  // Mode state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mode <= RUN;
    end else begin
      mode <= mode_next;
    end
  end

  // Mode sequencing RUN -> SET_TIME -> SET_ALARM -> RUN on set_mode
  always_comb begin
    mode_next = mode;
    if (do_set) begin
      case (mode)
        RUN:       mode_next = SET_TIME;
        SET_TIME:  mode_next = SET_ALARM;
        SET_ALARM: mode_next = RUN;
        default:   mode_next = RUN;
      endcase
    end
  end

  // One-second timebase, frozen at zero while the time is being set
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tb_cnt <= '0;
    end else if (mode == SET_TIME) begin
      tb_cnt <= '0;
    end else if (tb_cnt == TB_LAST) begin
      tb_cnt <= '0;
    end else begin
      tb_cnt <= tb_cnt + TB_W'(1);
    end
  end

  assign tick = (mode != SET_TIME) && (tb_cnt == TB_LAST);

  // Incremented field values and the time that a tick would produce
  always_comb begin
    hour_inc       = bcd_inc_wrap(hour_bcd, BCD_HOUR_MAX);
    min_inc        = bcd_inc_wrap(min_bcd, BCD_MIN_MAX);
    sec_inc        = bcd_inc_wrap(sec_bcd, BCD_SEC_MAX);
    alarm_hour_inc = bcd_inc_wrap(alarm_hour, BCD_HOUR_MAX);
    alarm_min_inc  = bcd_inc_wrap(alarm_min, BCD_MIN_MAX);
    next_min       = (sec_bcd == BCD_SEC_MAX) ? min_inc : min_bcd;
    next_hour      = ((sec_bcd == BCD_SEC_MAX) && (min_bcd == BCD_MIN_MAX)) ? hour_inc : hour_bcd;
    ring_start     = tick && armed && ((mode == RUN) || (mode == SET_ALARM)) &&
                     (sec_inc == 8'h00) && (next_min == alarm_min) && (next_hour == alarm_hour);
  end

  // Time of day: carrying count on ticks, independent wrapping fields in SET_TIME
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hour_bcd <= 8'h00;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
    end else if (tick) begin
      sec_bcd  <= sec_inc;
      min_bcd  <= next_min;
      hour_bcd <= next_hour;
    end else if (mode == SET_TIME) begin
      if (do_hour) hour_bcd <= hour_inc;
      if (do_min)  min_bcd  <= min_inc;
      if (do_sec)  sec_bcd  <= sec_inc;
    end
  end

  // Alarm setting: hour/min fields and the armed toggle on the sec button
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      alarm_hour <= 8'h00;
      alarm_min  <= 8'h00;
      armed      <= 1'b0;
    end else if (mode == SET_ALARM) begin
      if (do_hour) alarm_hour <= alarm_hour_inc;
      if (do_min)  alarm_min  <= alarm_min_inc;
      if (do_sec)  armed      <= ~armed;
    end
  end

  // Ringing lasts RING_TICKS further ticks unless silenced; blink restarts low at ring start
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ringing   <= 1'b0;
      ring_left <= '0;
      blink     <= 1'b0;
    end else begin
      if (ring_start) begin
        blink <= 1'b0;
      end else if (tick) begin
        blink <= ~blink;
      end

      if (ring_start) begin
        ringing   <= 1'b1;
        ring_left <= RING_TICKS;
      end else if (silence || enter_set_time) begin
        ringing   <= 1'b0;
        ring_left <= '0;
      end else if (tick && ringing) begin
        if (ring_left <= AL_W'(1)) begin
          ringing   <= 1'b0;
          ring_left <= '0;
        end else begin
          ring_left <= ring_left - AL_W'(1);
        end
      end
    end
  end

  // Choose what the digits show; blank nibbles in the seconds slot during SET_ALARM
  always_comb begin
    disp_hour = hour_bcd;
    disp_min  = min_bcd;
    disp_sec  = sec_bcd;
    if (mode == SET_ALARM) begin
      disp_hour = alarm_hour;
      disp_min  = alarm_min;
      disp_sec  = 8'hFF;
    end
  end

  bcd_to_7seg u_hour_1 (.bcd(disp_hour[7:4]), .seg(seg_hour_1));
  bcd_to_7seg u_hour_2 (.bcd(disp_hour[3:0]), .seg(seg_hour_2));
  bcd_to_7seg u_min_1  (.bcd(disp_min[7:4]),  .seg(seg_min_1));
  bcd_to_7seg u_min_2  (.bcd(disp_min[3:0]),  .seg(seg_min_2));
  bcd_to_7seg u_sec_1  (.bcd(disp_sec[7:4]),  .seg(seg_sec_1));
  bcd_to_7seg u_sec_2  (.bcd(disp_sec[3:0]),  .seg(seg_sec_2));

  assign mode_bits = mode;

  // Registered display and status outputs
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hour_1 <= SEG_0;
      hour_2 <= SEG_0;
      min_1  <= SEG_0;
      min_2  <= SEG_0;
      sec_1  <= SEG_0;
      sec_2  <= SEG_0;
      leds   <= 8'h00;
    end else begin
      hour_1 <= seg_hour_1;
      hour_2 <= seg_hour_2;
      min_1  <= seg_min_1;
      min_2  <= seg_min_2;
      sec_1  <= seg_sec_1;
      sec_2  <= seg_sec_2;
      leds   <= {ringing & blink, armed, 4'b0000, mode_bits};
    end
  end

endmodule
